lattice_result_arbiter: RTL and testbench

- Collects per-core success pulses from NUM_CORES lattice cores and shares one result channel to the host/controller among them.
- Records a timestamp per success. The timestamp is the cycle count since job start, so the host can reconstruct the winning nonce.
- Presents results one at a time over a valid/ready handshake, using round-robin fairness.

---
 rtl/lattice_result_arbiter.sv | 133 +++++++++++++
 tb/tb_lattice_result_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lattice_result_arbiter.sv
// Round-robin arbiter that timestamps per-core success pulses and presents them one at a time.
// Optional LATTICE_ARB_DROP_COUNT_EN adds a saturating drop_count output behind the dropped flag.
module lattice_result_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2,
    parameter int STAMP_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_start,
    input  logic [NUM_CORES-1:0] core_success,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDX_W-1:0]     res_index,
    output logic [STAMP_W-1:0]   res_stamp,
    output logic [NUM_CORES-1:0] pending,
`ifdef LATTICE_ARB_DROP_COUNT_EN
    output logic [15:0]          drop_count,
`endif
    output logic                 dropped
);

    logic [STAMP_W-1:0]   counter;
    logic [STAMP_W-1:0]   stamp [NUM_CORES];
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     winner;
    logic                 any_pending;
    logic                 load;
    logic [NUM_CORES-1:0] capture;
    logic [NUM_CORES-1:0] drop_vec;
    int                   scan_idx;

    // Scan registered pending flags starting at ptr, wrapping modulo NUM_CORES.
    always_comb begin
        winner      = '0;
        any_pending = 1'b0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = (int'(ptr) + k) % NUM_CORES;
            if (!any_pending && pending[scan_idx]) begin
                any_pending = 1'b1;
                winner      = IDX_W'(scan_idx);
            end
        end
    end

    assign load = !job_start && (!res_valid || res_ready) && any_pending;

    // A core being granted this cycle frees its slot, so a same-cycle success re-arms it.
    always_comb begin
        capture  = '0;
        drop_vec = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!job_start && core_success[i]) begin
                if (!pending[i] || (load && winner == IDX_W'(i)))
                    capture[i] = 1'b1;
                else
                    drop_vec[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter   <= '0;
            ptr       <= '0;
            pending   <= '0;
            res_valid <= 1'b0;
            res_index <= '0;
            res_stamp <= '0;
            for (int i = 0; i < NUM_CORES; i++)
                stamp[i] <= '0;
        end else if (job_start) begin
            counter   <= '0;
            ptr       <= '0;
            pending   <= '0;
            res_valid <= 1'b0;
        end else begin
            counter <= (counter == {STAMP_W{1'b1}}) ? counter : counter + 1'b1;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (capture[i]) begin
                    pending[i] <= 1'b1;
                    stamp[i]   <= counter;
                end else if (load && winner == IDX_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
            if (load) begin
                res_valid <= 1'b1;
                res_index <= winner;
                res_stamp <= stamp[winner];
                ptr       <= IDX_W'((int'(winner) + 1) % NUM_CORES);
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef LATTICE_ARB_DROP_COUNT_EN
    logic [4:0]  drop_num;
    logic [16:0] drop_sum;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_CORES; i++)
            drop_num = drop_num + {4'b0, drop_vec[i]};
        drop_sum = {1'b0, drop_count} + {12'b0, drop_num};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_count <= '0;
        else if (job_start)
            drop_count <= '0;
        else if (drop_sum[16])
            drop_count <= 16'hFFFF;
        else
            drop_count <= drop_sum[15:0];
    end

    assign dropped = (drop_count != 16'd0);
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dropped <= 1'b0;
        else if (job_start)
            dropped <= 1'b0;
        else if (|drop_vec)
            dropped <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_lattice_result_arbiter.sv
// Randomized and directed bench for lattice_result_arbiter against a cycle-level reference model.
// A second instance with STAMP_W=4 shares the stimulus to exercise counter saturation.
module tb_lattice_result_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_start;
    logic [N-1:0] core_success;
    logic         res_ready;

    logic         res_valid, s_valid;
    logic [1:0]   res_index, s_index;
    logic [31:0]  res_stamp;
    logic [3:0]   s_stamp;
    logic [N-1:0] pending, s_pending;
    logic         dropped, s_dropped;
`ifdef LATTICE_ARB_DROP_COUNT_EN
    logic [15:0]  drop_count, s_drop_count;
`endif

    lattice_result_arbiter #(.NUM_CORES(N), .IDX_W(2), .STAMP_W(32)) dut (
        .clk(clk), .rst(rst), .job_start(job_start), .core_success(core_success),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
        .res_stamp(res_stamp), .pending(pending),
`ifdef LATTICE_ARB_DROP_COUNT_EN
        .drop_count(drop_count),
`endif
        .dropped(dropped)
    );

    lattice_result_arbiter #(.NUM_CORES(N), .IDX_W(2), .STAMP_W(4)) u_sat (
        .clk(clk), .rst(rst), .job_start(job_start), .core_success(core_success),
        .res_valid(s_valid), .res_ready(res_ready), .res_index(s_index),
        .res_stamp(s_stamp), .pending(s_pending),
`ifdef LATTICE_ARB_DROP_COUNT_EN
        .drop_count(s_drop_count),
`endif
        .dropped(s_dropped)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: what the host should see, derived from the behavioural rules.
    bit          m_pend [N];
    logic [31:0] m_stamp [N];
    logic [31:0] m_cnt;
    int          m_ptr;
    bit          m_valid;
    int          m_idx;
    logic [31:0] m_rstamp;
    bit          m_drop;
    int          m_dcnt;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i]  = 1'b0;
            m_stamp[i] = '0;
        end
        m_cnt = '0; m_ptr = 0; m_valid = 1'b0; m_idx = 0;
        m_rstamp = '0; m_drop = 1'b0; m_dcnt = 0;
    endtask

    task automatic model_update(input bit js, input logic [N-1:0] cs, input bit rdy);
        bit          load;
        bit          found;
        int          win;
        int          c;
        int          nd;
        bit          np [N];
        logic [31:0] ns [N];
        if (js) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_valid = 1'b0; m_drop = 1'b0; m_dcnt = 0; m_ptr = 0; m_cnt = '0;
            return;
        end
        found = 1'b0; win = 0;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && m_pend[c]) begin found = 1'b1; win = c; end
        end
        load = (!m_valid || rdy) && found;
        np = m_pend;
        ns = m_stamp;
        if (load) np[win] = 1'b0;
        nd = 0;
        for (int i = 0; i < N; i++) begin
            if (cs[i]) begin
                if (!m_pend[i] || (load && win == i)) begin
                    np[i] = 1'b1;
                    ns[i] = m_cnt;
                end else begin
                    nd++;
                end
            end
        end
        if (load) begin
            m_valid = 1'b1; m_idx = win; m_rstamp = m_stamp[win]; m_ptr = (win + 1) % N;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_pend = np;
        m_stamp = ns;
        if (nd > 0) m_drop = 1'b1;
        m_dcnt = (m_dcnt + nd > 65535) ? 65535 : m_dcnt + nd;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    endtask

    function automatic logic [3:0] model_pend_vec();
        logic [3:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic compare_all();
        check_eq("res_valid", {31'b0, res_valid}, {31'b0, m_valid});
        check_eq("pending", {28'b0, pending}, {28'b0, model_pend_vec()});
        check_eq("dropped", {31'b0, dropped}, {31'b0, m_drop});
        check_eq("sat_valid", {31'b0, s_valid}, {31'b0, m_valid});
        check_eq("sat_pending", {28'b0, s_pending}, {28'b0, model_pend_vec()});
        if (m_valid) begin
            check_eq("res_index", {30'b0, res_index}, m_idx);
            check_eq("res_stamp", res_stamp, m_rstamp);
            check_eq("sat_index", {30'b0, s_index}, m_idx);
            check_eq("sat_stamp", {28'b0, s_stamp}, (m_rstamp > 15) ? 32'd15 : m_rstamp);
        end
`ifdef LATTICE_ARB_DROP_COUNT_EN
        check_eq("drop_count", {16'b0, drop_count}, m_dcnt);
`endif
    endtask

    task automatic step(input bit js, input logic [N-1:0] cs, input bit rdy);
        job_start = js; core_success = cs; res_ready = rdy;
        @(posedge clk);
        model_update(js, cs, rdy);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, {31'b0, res_valid}, 32'd0);
        check_eq({tag, "_index"}, {30'b0, res_index}, 32'd0);
        check_eq({tag, "_stamp"}, res_stamp, 32'd0);
        check_eq({tag, "_pending"}, {28'b0, pending}, 32'd0);
        check_eq({tag, "_dropped"}, {31'b0, dropped}, 32'd0);
        check_eq({tag, "_sat_stamp"}, {28'b0, s_stamp}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; job_start = 1'b0; core_success = '0; res_ready = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Single success sampled at counter 10.
        step(1'b1, 4'b0000, 1'b1);
        repeat (10) step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        check_eq("t1_index", {30'b0, res_index}, 32'd2);
        check_eq("t1_stamp", res_stamp, 32'd10);
        check_eq("t1_valid", {31'b0, res_valid}, 32'd1);
        step(1'b0, 4'b0000, 1'b1);
        check_eq("t1_single", {31'b0, res_valid}, 32'd0);

        // Round-robin order 0,1,3 then wrap to core 0.
        step(1'b1, 4'b0000, 1'b1);
        step(1'b0, 4'b1011, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        check_eq("t2_first", {30'b0, res_index}, 32'd0);
        step(1'b0, 4'b0000, 1'b1);
        check_eq("t2_second", {30'b0, res_index}, 32'd1);
        step(1'b0, 4'b0001, 1'b1);
        check_eq("t2_third", {30'b0, res_index}, 32'd3);
        step(1'b0, 4'b0000, 1'b1);
        check_eq("t2_wrap", {30'b0, res_index}, 32'd0);

        // Backpressure holds the presented result.
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0110, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0000, 1'b0);
            check_eq("t3_hold", {30'b0, res_index}, 32'd1);
        end
        step(1'b0, 4'b0000, 1'b1);
        check_eq("t3_next", {30'b0, res_index}, 32'd2);
        step(1'b0, 4'b0000, 1'b1);
        check_eq("t3_idle", {31'b0, res_valid}, 32'd0);

        // Repeat success on an already-pending core.
        step(1'b0, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        check_eq("t4_dropped", {31'b0, dropped}, 32'd1);
`ifdef LATTICE_ARB_DROP_COUNT_EN
        check_eq("t4_drop_count", {16'b0, drop_count}, 32'd1);
`endif
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0011, 1'b0);

        // job_start overrides everything in flight.
        step(1'b1, 4'b1000, 1'b0);
        check_eq("t5_valid", {31'b0, res_valid}, 32'd0);
        check_eq("t5_pending", {28'b0, pending}, 32'd0);
        check_eq("t5_dropped", {31'b0, dropped}, 32'd0);
        step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        check_eq("t5_stamp0", res_stamp, 32'd0);

        // Saturation of the narrow counter.
        step(1'b1, 4'b0000, 1'b1);
        repeat (20) step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        check_eq("t6_sat", {28'b0, s_stamp}, 32'd15);
        check_eq("t6_wide", res_stamp, 32'd20);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [N-1:0] cs;
            for (int i = 0; i < N; i++) cs[i] = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 99) == 0, cs, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset during a stalled handshake.
        step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        check_eq("t7_pre_valid", {31'b0, res_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_rst");
        @(negedge clk) rst = 1'b1;
        step(1'b0, 4'b0010, 1'b1);
        step(1'b0, 4'b0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
